// File: rtl/uart_rx_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_deserializer
// Purpose  : Receive-side UART engine. Synchronises and oversamples RXD,
//            recovers 16550-style async frames (5..8 data bits, optional
//            parity, one checked stop bit) and stores each character with
//            its parity/framing/break status in a show-ahead RX FIFO.
// Ports    : clock, PRESETn         - clock, async active-low reset
//            baud_tick              - one-cycle enable at OSR x baud
//            RXD                    - serial input (idle high, async)
//            lcr_wls/pen/eps        - frame format (latched per frame)
//            rd_en, fifo_clr        - FIFO pop / synchronous flush
//            rx_data/perr/ferr/brk  - FIFO head entry (0 when empty)
//            rx_fifo_empty/full/count, overrun_pulse, rx_busy - status
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_deserializer #(
  parameter int FIFO_DEPTH = 16,
  parameter int OSR        = 16
) (
  input  logic                          clock,
  input  logic                          PRESETn,
  input  logic                          baud_tick,
  input  logic                          RXD,
  input  logic [1:0]                    lcr_wls,
  input  logic                          lcr_pen,
  input  logic                          lcr_eps,
  input  logic                          rd_en,
  input  logic                          fifo_clr,
  output logic [7:0]                    rx_data,
  output logic                          rx_perr,
  output logic                          rx_ferr,
  output logic                          rx_brk,
  output logic                          rx_fifo_empty,
  output logic                          rx_fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   rx_fifo_count,
  output logic                          overrun_pulse,
  output logic                          rx_busy
);

  localparam int c_cnt_w = $clog2(OSR);
  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(OSR/2 - 1);
  localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(OSR - 1);
  localparam logic [c_ptr_w:0]   c_depth     = (c_ptr_w+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } state_t;

  // --------------------------------------------------------------------------
  // RXD synchroniser (idle-high reset value so no false start after reset)
  // --------------------------------------------------------------------------
  logic rxd_s1_q, rxd_s2_q;

  always_ff @(posedge clock or negedge PRESETn) begin
    if (!PRESETn) begin
      rxd_s1_q <= 1'b1;
      rxd_s2_q <= 1'b1;
    end else begin
      rxd_s1_q <= RXD;
      rxd_s2_q <= rxd_s1_q;
    end
  end

  // --------------------------------------------------------------------------
  // Frame FSM
  // --------------------------------------------------------------------------
  state_t               state_q, state_d;
  logic [c_cnt_w-1:0]   cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [7:0]           data_q, data_d;
  logic                 par_q, par_d;
  logic                 perr_q, perr_d;
  logic [1:0]           wls_q, wls_d;
  logic                 pen_q, pen_d;
  logic                 eps_q, eps_d;
  logic                 w_push;
  logic                 w_ferr;
  logic                 w_brk;

  always_ff @(posedge clock or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
      wls_q   <= '0;
      pen_q   <= 1'b0;
      eps_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      par_q   <= par_d;
      perr_q  <= perr_d;
      wls_q   <= wls_d;
      pen_q   <= pen_d;
      eps_q   <= eps_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    data_d  = data_q;
    par_d   = par_q;
    perr_d  = perr_q;
    wls_d   = wls_q;
    pen_d   = pen_q;
    eps_d   = eps_q;
    w_push  = 1'b0;
    w_ferr  = 1'b0;
    w_brk   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (baud_tick && !rxd_s2_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end

      // Re-check the line at mid start bit to reject glitches.
      S_START: begin
        if (baud_tick) begin
          if (cnt_q == c_half_last) begin
            cnt_d = '0;
            if (!rxd_s2_q) begin
              state_d = S_DATA;
              bit_d   = '0;
              data_d  = '0;
              par_d   = 1'b0;
              perr_d  = 1'b0;
              wls_d   = lcr_wls;
              pen_d   = lcr_pen;
              eps_d   = lcr_eps;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q + c_cnt_w'(1);
          end
        end
      end

      S_DATA: begin
        if (baud_tick) begin
          if (cnt_q == c_bit_last) begin
            cnt_d          = '0;
            data_d[bit_q]  = rxd_s2_q;
            if (bit_q == ({1'b0, wls_q} + 3'd4)) begin
              state_d = pen_q ? S_PARITY : S_STOP;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + c_cnt_w'(1);
          end
        end
      end

      // Even: XOR of data and parity bit must be 0; odd: must be 1.
      S_PARITY: begin
        if (baud_tick) begin
          if (cnt_q == c_bit_last) begin
            cnt_d   = '0;
            par_d   = rxd_s2_q;
            perr_d  = ((^data_q) ^ rxd_s2_q) != ~eps_q;
            state_d = S_STOP;
          end else begin
            cnt_d = cnt_q + c_cnt_w'(1);
          end
        end
      end

      // par_q stays 0 when parity is disabled, so the break term needs no
      // separate enable qualifier.
      S_STOP: begin
        if (baud_tick) begin
          if (cnt_q == c_bit_last) begin
            cnt_d   = '0;
            w_ferr  = !rxd_s2_q;
            w_brk   = w_ferr && (data_q == 8'h00) && !par_q;
            w_push  = 1'b1;
            state_d = w_ferr ? S_WAIT_HIGH : S_IDLE;
          end else begin
            cnt_d = cnt_q + c_cnt_w'(1);
          end
        end
      end

      // Hold off new start detection until the line has returned high.
      S_WAIT_HIGH: begin
        if (rxd_s2_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rx_busy = (state_q != S_IDLE);

  // --------------------------------------------------------------------------
  // RX FIFO: {brk, ferr, perr, data[7:0]}
  // --------------------------------------------------------------------------
  logic [10:0]        mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0] wptr_q, rptr_q;
  logic [c_ptr_w:0]   count_q;
  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic               w_push_ok;
  logic [10:0]        w_head;

  assign w_full    = (count_q == c_depth);
  assign w_empty   = (count_q == '0);
  assign w_pop     = rd_en && !w_empty && !fifo_clr;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push_ok = w_push && (!w_full || w_pop) && !fifo_clr;
  assign overrun_pulse = w_push && w_full && !rd_en && !fifo_clr;

  always_ff @(posedge clock or negedge PRESETn) begin
    if (!PRESETn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (fifo_clr) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (w_push_ok) begin
        wptr_q <= wptr_q + c_ptr_w'(1);
      end
      if (w_pop) begin
        rptr_q <= rptr_q + c_ptr_w'(1);
      end
      if (w_push_ok && !w_pop) begin
        count_q <= count_q + (c_ptr_w+1)'(1);
      end else if (!w_push_ok && w_pop) begin
        count_q <= count_q - (c_ptr_w+1)'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_push_ok) begin
      mem[wptr_q] <= {w_brk, w_ferr, perr_q, data_q};
    end
  end

  assign w_head        = w_empty ? 11'd0 : mem[rptr_q];
  assign rx_data       = w_head[7:0];
  assign rx_perr       = w_head[8];
  assign rx_ferr       = w_head[9];
  assign rx_brk        = w_head[10];
  assign rx_fifo_empty = w_empty;
  assign rx_fifo_full  = w_full;
  assign rx_fifo_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_deserializer
// Purpose  : Self-checking bench for uart_rx_deserializer. Frame-format
//            vectors from a table plus hand-written glitch, break, overrun,
//            flush and mid-frame-reset sequences; FIFO contents checked
//            against a scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_deserializer;

  localparam int FIFO_DEPTH = 16;
  localparam int OSR        = 16;
  localparam int BIT_CLKS   = 2 * OSR;   // baud_tick every other clock

  logic        clock;
  logic        PRESETn;
  logic        baud_tick;
  logic        RXD;
  logic [1:0]  lcr_wls;
  logic        lcr_pen;
  logic        lcr_eps;
  logic        rd_en;
  logic        fifo_clr;
  logic [7:0]  rx_data;
  logic        rx_perr;
  logic        rx_ferr;
  logic        rx_brk;
  logic        rx_fifo_empty;
  logic        rx_fifo_full;
  logic [4:0]  rx_fifo_count;
  logic        overrun_pulse;
  logic        rx_busy;

  uart_rx_deserializer #(.FIFO_DEPTH(FIFO_DEPTH), .OSR(OSR)) dut (
    .clock         (clock),
    .PRESETn       (PRESETn),
    .baud_tick     (baud_tick),
    .RXD           (RXD),
    .lcr_wls       (lcr_wls),
    .lcr_pen       (lcr_pen),
    .lcr_eps       (lcr_eps),
    .rd_en         (rd_en),
    .fifo_clr      (fifo_clr),
    .rx_data       (rx_data),
    .rx_perr       (rx_perr),
    .rx_ferr       (rx_ferr),
    .rx_brk        (rx_brk),
    .rx_fifo_empty (rx_fifo_empty),
    .rx_fifo_full  (rx_fifo_full),
    .rx_fifo_count (rx_fifo_count),
    .overrun_pulse (overrun_pulse),
    .rx_busy       (rx_busy)
  );

  typedef struct {
    logic [1:0] wls;
    logic       pen;
    logic       eps;
    logic [7:0] data;
    logic       parbit;
    logic       stopbit;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
    logic       exp_brk;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       f;
    logic       b;
  } exp_t;

  vec_t vecs [9];
  exp_t sb [$];
  int   checks  = 0;
  int   errors  = 0;
  int   ovr_cnt = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    baud_tick = 1'b0;
    forever begin
      @(negedge clock);
      baud_tick = ~baud_tick;
    end
  end

  always @(negedge clock) begin
    if (overrun_pulse) ovr_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clock);
    RXD = b;
    repeat (BIT_CLKS - 1) @(negedge clock);
  endtask

  task automatic send_frame(input logic [1:0] wls, input logic pen, input logic parbit,
                            input logic [7:0] data, input logic stopbit);
    send_bit(1'b0);
    for (int i = 0; i < 5 + int'(wls); i++) send_bit(data[i]);
    if (pen) send_bit(parbit);
    send_bit(stopbit);
    send_bit(1'b1);
  endtask

  task automatic push_exp(input logic [7:0] d, input logic p, input logic f, input logic b);
    exp_t e;
    e.d = d; e.p = p; e.f = f; e.b = b;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string name);
    exp_t e;
    @(negedge clock);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got %0h expected entry", name, rx_data);
    end else begin
      e = sb.pop_front();
      check(name, {21'd0, rx_brk, rx_ferr, rx_perr, rx_data}, {21'd0, e.b, e.f, e.p, e.d});
    end
    rd_en = 1'b1;
    @(negedge clock);
    rd_en = 1'b0;
  endtask

  initial begin
    //        wls  pen  eps  data   par  stop  exp_d  perr ferr brk
    vecs[0] = '{2'd3, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{2'd2, 1'b1, 1'b1, 8'h41, 1'b1, 1'b1, 8'h41, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{2'd2, 1'b1, 1'b1, 8'h41, 1'b0, 1'b1, 8'h41, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{2'd0, 1'b1, 1'b0, 8'h15, 1'b0, 1'b1, 8'h15, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{2'd1, 1'b1, 1'b0, 8'h3F, 1'b0, 1'b1, 8'h3F, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{2'd3, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{2'd3, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{2'd3, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{2'd0, 1'b0, 1'b0, 8'hF5, 1'b0, 1'b1, 8'h15, 1'b0, 1'b0, 1'b0};

    PRESETn  = 1'b0;
    RXD      = 1'b1;
    rd_en    = 1'b0;
    fifo_clr = 1'b0;
    lcr_wls  = 2'd3;
    lcr_pen  = 1'b0;
    lcr_eps  = 1'b0;
    repeat (5) @(negedge clock);

    // Reset state
    check("rst_empty",   32'(rx_fifo_empty), 32'd1);
    check("rst_full",    32'(rx_fifo_full),  32'd0);
    check("rst_count",   32'(rx_fifo_count), 32'd0);
    check("rst_head",    {21'd0, rx_brk, rx_ferr, rx_perr, rx_data}, 32'd0);
    check("rst_overrun", 32'(overrun_pulse), 32'd0);
    check("rst_busy",    32'(rx_busy),       32'd0);
    PRESETn = 1'b1;
    repeat (4) @(negedge clock);

    // Table-driven frame formats
    for (int v = 0; v < 9; v++) begin
      lcr_wls = vecs[v].wls;
      lcr_pen = vecs[v].pen;
      lcr_eps = vecs[v].eps;
      send_frame(vecs[v].wls, vecs[v].pen, vecs[v].parbit, vecs[v].data, vecs[v].stopbit);
      push_exp(vecs[v].exp_data, vecs[v].exp_perr, vecs[v].exp_ferr, vecs[v].exp_brk);
      check($sformatf("vec%0d_count", v), 32'(rx_fifo_count), 32'd1);
      check($sformatf("vec%0d_busy", v),  32'(rx_busy),       32'd0);
      pop_check($sformatf("vec%0d_entry", v));
      check($sformatf("vec%0d_empty", v), 32'(rx_fifo_empty), 32'd1);
    end

    // Start-bit glitch shorter than half a bit: rejected, nothing pushed
    lcr_wls = 2'd3; lcr_pen = 1'b0; lcr_eps = 1'b0;
    @(negedge clock);
    RXD = 1'b0;
    repeat (BIT_CLKS / 4) @(negedge clock);
    RXD = 1'b1;
    repeat (4 * BIT_CLKS) @(negedge clock);
    check("glitch_count", 32'(rx_fifo_count), 32'd0);
    check("glitch_busy",  32'(rx_busy),       32'd0);

    // Break: line low for ~3 frames -> single break entry, no restart while low
    @(negedge clock);
    RXD = 1'b0;
    repeat (30 * BIT_CLKS) @(negedge clock);
    push_exp(8'h00, 1'b0, 1'b1, 1'b1);
    check("brk_count_low", 32'(rx_fifo_count), 32'd1);
    check("brk_busy_low",  32'(rx_busy),       32'd1);
    RXD = 1'b1;
    repeat (BIT_CLKS) @(negedge clock);
    check("brk_busy_high",  32'(rx_busy),       32'd0);
    check("brk_count_high", 32'(rx_fifo_count), 32'd1);
    pop_check("brk_entry");

    // Overrun: 17 frames with no reads
    ovr_cnt = 0;
    for (int k = 0; k < 17; k++) begin
      send_frame(2'd3, 1'b0, 1'b0, 8'h10 + 8'(k), 1'b1);
      if (k < FIFO_DEPTH) push_exp(8'h10 + 8'(k), 1'b0, 1'b0, 1'b0);
      if (k == FIFO_DEPTH - 2) check("ovr_no_pulse_yet", 32'(ovr_cnt), 32'd0);
    end
    check("ovr_full",   32'(rx_fifo_full),  32'd1);
    check("ovr_count",  32'(rx_fifo_count), 32'd16);
    check("ovr_pulses", 32'(ovr_cnt),       32'd1);
    check("ovr_head",   32'(rx_data),       32'h10);
    for (int k = 0; k < FIFO_DEPTH; k++) pop_check($sformatf("ovr_drain%0d", k));
    check("ovr_empty", 32'(rx_fifo_empty), 32'd1);

    // Synchronous flush
    send_frame(2'd3, 1'b0, 1'b0, 8'h11, 1'b1);
    send_frame(2'd3, 1'b0, 1'b0, 8'h22, 1'b1);
    check("clr_count_before", 32'(rx_fifo_count), 32'd2);
    fifo_clr = 1'b1;
    @(negedge clock);
    fifo_clr = 1'b0;
    check("clr_count_after", 32'(rx_fifo_count), 32'd0);
    check("clr_empty",       32'(rx_fifo_empty),  32'd1);
    check("clr_head",        32'(rx_data),        32'd0);

    // Reset during DATA aborts the frame
    @(negedge clock);
    RXD = 1'b0;
    repeat (3 * BIT_CLKS) @(negedge clock);
    check("mid_busy", 32'(rx_busy), 32'd1);
    PRESETn = 1'b0;
    RXD     = 1'b1;
    repeat (3) @(negedge clock);
    check("mid_rst_empty", 32'(rx_fifo_empty), 32'd1);
    check("mid_rst_busy",  32'(rx_busy),       32'd0);
    PRESETn = 1'b1;
    repeat (4 * BIT_CLKS) @(negedge clock);
    check("mid_rst_count_idle", 32'(rx_fifo_count), 32'd0);
    send_frame(2'd3, 1'b0, 1'b0, 8'h3C, 1'b1);
    push_exp(8'h3C, 1'b0, 1'b0, 1'b0);
    check("mid_rst_count", 32'(rx_fifo_count), 32'd1);
    pop_check("mid_rst_entry");
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
